// File: rtl/mdu_e_pkg.sv
// Shared constants for the E-stage multiply/divide unit: operation codes,
// default latencies, FSM state type and the HI/LO writeback select codes.
package mdu_e_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Register-file writeback mux selects for mfhi/mflo.
  localparam logic [2:0] RF_WD_HI = 3'd3;
  localparam logic [2:0] RF_WD_LO = 3'd4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_e_calc.sv
// Combinational result generator: produces the 64-bit HI/LO result for
// mult/multu/div/divu, holding the current HI/LO on a divide by zero.
module mdu_calc
  import mdu_e_pkg::*;
(
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] HI,
  input  logic [31:0] LO,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] q_abs;
  logic [31:0] r_abs;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic        div_zero;

  // Low 64 bits of a sign-extended product equal the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide via magnitudes; quotient truncates toward zero and the
  // remainder follows the dividend sign.
  assign a_abs    = A[31] ? (~A + 32'd1) : A;
  assign b_abs    = B[31] ? (~B + 32'd1) : B;
  assign div_zero = (B == 32'd0);
  assign q_abs    = div_zero ? 32'd0 : (a_abs / b_abs);
  assign r_abs    = div_zero ? 32'd0 : (a_abs % b_abs);
  assign q_s      = (A[31] ^ B[31]) ? (~q_abs + 32'd1) : q_abs;
  assign r_s      = A[31] ? (~r_abs + 32'd1) : r_abs;

  always_comb begin
    hi_n = HI;
    lo_n = LO;
    case (mdu_op)
      MDU_MULT: begin
        hi_n = prod_s[63:32];
        lo_n = prod_s[31:0];
      end
      MDU_MULTU: begin
        hi_n = prod_u[63:32];
        lo_n = prod_u[31:0];
      end
      MDU_DIV: begin
        if (!div_zero) begin
          hi_n = r_s;
          lo_n = q_s;
        end
      end
      MDU_DIVU: begin
        if (!div_zero) begin
          hi_n = A % B;
          lo_n = A / B;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: owns HI/LO, the busy FSM and its latency
// counter; results land in HI/LO on the edge where busy falls.
module mdu_e
  import mdu_e_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        mdu_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      hi_n_q, hi_n_d;
  logic [31:0]      lo_n_q, lo_n_d;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             start;

  mdu_calc u_calc (
    .mdu_op (mdu_op),
    .A      (A),
    .B      (B),
    .HI     (hi_q),
    .LO     (lo_q),
    .hi_n   (calc_hi),
    .lo_n   (calc_lo)
  );

  assign start     = is_start_op(mdu_op);
  assign busy      = (state_q == ST_RUN);
  assign mdu_stall = busy | start;
  assign HI        = hi_q;
  assign LO        = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_n_q  <= '0;
      lo_n_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_n_q  <= hi_n_d;
      lo_n_q  <= lo_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_n_d  = hi_n_q;
    lo_n_d  = lo_n_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hi_n_d  = calc_hi;
          lo_n_d  = calc_lo;
          cnt_d   = ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU)) ?
                    CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_d = ST_RUN;
        end else if (mdu_op == MDU_MTHI) begin
          hi_d = A;
        end else if (mdu_op == MDU_MTLO) begin
          lo_d = A;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_n_q;
          lo_d    = lo_n_q;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The stall unit should never present an operation while the unit is busy.
  always_ff @(posedge clk) begin
    if (!reset && busy) begin
      assert (mdu_op == MDU_NONE)
        else $warning("mdu_e: mdu_op %0d presented while busy, ignored", mdu_op);
    end
  end

endmodule

// File: tb/tb_mdu_e.sv
// Directed bench for mdu_e: each task drives one scenario and checks
// busy length, stall and HI/LO against hand-computed values.
module tb_mdu_e;
  import mdu_e_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mdu_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        mdu_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .mdu_op    (mdu_op),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .mdu_stall (mdu_stall),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start op, then count busy cycles (bounded); -1 means timeout.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic stall_seen, output int cycles);
    mdu_op = op; A = a; B = b;
    #1;
    stall_seen = mdu_stall;
    tick();
    mdu_op = MDU_NONE;
    cycles = 0;
    while (busy && cycles < 50) begin
      cycles++;
      tick();
    end
    if (busy) cycles = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mdu_op = MDU_NONE; A = '0; B = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mdu_stall !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++;
      $display("FAIL reset: busy=%b stall=%b HI=%h LO=%h required 0 0 0 0", busy, mdu_stall, HI, LO);
    end
    $display("reset: busy=%b HI=%h LO=%h", busy, HI, LO);
  endtask

  task automatic test_mult();
    logic st; int n;
    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, st, n);
    checks++;
    if (st !== 1'b1) begin
      failures++; $display("FAIL mult_stall: got %b required 1", st);
    end
    checks++;
    if (n !== 5) begin
      failures++; $display("FAIL mult_busy: got %0d cycles required 5", n);
    end
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      failures++; $display("FAIL mult_result: HI=%h LO=%h required FFFFFFFF FFFFFFFA", HI, LO);
    end
    $display("mult -2*3: busy=%0d HI=%h LO=%h", n, HI, LO);
  endtask

  task automatic test_multu_divu();
    logic st; int n;
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, st, n);
    checks++;
    if (n !== 5 || HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL multu: busy=%0d HI=%h LO=%h required 5 00000001 FFFFFFFE", n, HI, LO);
    end
    $display("multu: busy=%0d HI=%h LO=%h", n, HI, LO);
    run_op(MDU_DIVU, 32'd7, 32'd2, st, n);
    checks++;
    if (n !== 10 || st !== 1'b1) begin
      failures++; $display("FAIL divu_busy: busy=%0d stall=%b required 10 1", n, st);
    end
    checks++;
    if (HI !== 32'd1 || LO !== 32'd3) begin
      failures++; $display("FAIL divu_result: HI=%h LO=%h required 00000001 00000003", HI, LO);
    end
    $display("divu 7/2: busy=%0d HI=%h LO=%h", n, HI, LO);
  endtask

  task automatic test_div();
    logic st; int n;
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, st, n);
    checks++;
    if (n !== 10 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      failures++; $display("FAIL div_neg: busy=%0d HI=%h LO=%h required 10 FFFFFFFF FFFFFFFD", n, HI, LO);
    end
    $display("div -7/2: busy=%0d HI=%h LO=%h", n, HI, LO);
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, n);
    checks++;
    if (n !== 10 || HI !== 32'd0 || LO !== 32'h8000_0000) begin
      failures++; $display("FAIL div_ovf: busy=%0d HI=%h LO=%h required 10 00000000 80000000", n, HI, LO);
    end
    $display("div min/-1: busy=%0d HI=%h LO=%h", n, HI, LO);
  endtask

  task automatic test_mthi_mtlo();
    logic st; int n;
    mdu_op = MDU_MTHI; A = 32'h1234_5678; B = '0;
    #1;
    checks++;
    if (mdu_stall !== 1'b0) begin
      failures++; $display("FAIL mthi_stall: got %b required 0", mdu_stall);
    end
    tick();
    mdu_op = MDU_MTLO; A = 32'h9ABC_DEF0;
    checks++;
    if (HI !== 32'h1234_5678 || busy !== 1'b0) begin
      failures++; $display("FAIL mthi: HI=%h busy=%b required 12345678 0", HI, busy);
    end
    tick();
    mdu_op = MDU_NONE;
    checks++;
    if (LO !== 32'h9ABC_DEF0 || HI !== 32'h1234_5678 || busy !== 1'b0) begin
      failures++; $display("FAIL mtlo: HI=%h LO=%h busy=%b required 12345678 9ABCDEF0 0", HI, LO, busy);
    end
    $display("mthi/mtlo: HI=%h LO=%h", HI, LO);
    run_op(MDU_DIV, 32'd100, 32'd0, st, n);
    checks++;
    if (n !== 10 || HI !== 32'h1234_5678 || LO !== 32'h9ABC_DEF0) begin
      failures++; $display("FAIL div_zero: busy=%0d HI=%h LO=%h required 10 12345678 9ABCDEF0", n, HI, LO);
    end
    $display("div by zero: busy=%0d HI=%h LO=%h", n, HI, LO);
  endtask

  task automatic test_busy_ignore();
    int n;
    mdu_op = MDU_MULT; A = 32'd6; B = 32'd7;
    tick();                                   // busy cycle 1
    mdu_op = MDU_NONE;
    tick();                                   // busy cycle 2
    mdu_op = MDU_MTLO; A = 32'h0000_DEAD;
    #1;
    checks++;
    if (mdu_stall !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL ignore_stall: stall=%b busy=%b required 1 1", mdu_stall, busy);
    end
    tick();                                   // busy cycle 3
    mdu_op = MDU_DIVU; A = 32'd100; B = 32'd3;
    tick();                                   // busy cycle 4
    mdu_op = MDU_NONE;
    n = 3;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 5 || HI !== 32'd0 || LO !== 32'd42) begin
      failures++; $display("FAIL busy_ignore: busy=%0d HI=%h LO=%h required 5 00000000 0000002A", n, HI, LO);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || LO !== 32'd42) begin
      failures++; $display("FAIL ignore_no_start: busy=%b LO=%h required 0 0000002A", busy, LO);
    end
    $display("busy ignore: busy=%0d HI=%h LO=%h", n, HI, LO);
  endtask

  task automatic test_back_to_back();
    logic st; int n;
    run_op(MDU_MULTU, 32'd9, 32'd9, st, n);
    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, n);
    checks++;
    if (n !== 5 || HI !== 32'd0 || LO !== 32'd1) begin
      failures++; $display("FAIL back_to_back: busy=%0d HI=%h LO=%h required 5 00000000 00000001", n, HI, LO);
    end
    $display("back-to-back mult -1*-1: busy=%0d HI=%h LO=%h", n, HI, LO);
  endtask

  task automatic test_reset_midflight();
    int late;
    mdu_op = MDU_MULT; A = 32'd3; B = 32'd4;
    tick();
    mdu_op = MDU_NONE;
    tick(); tick();                           // now in busy cycle 3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      failures++; $display("FAIL reset_mid: busy=%b HI=%h LO=%h required 0 0 0", busy, HI, LO);
    end
    late = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) late++;
    end
    checks++;
    if (late !== 0) begin
      failures++; $display("FAIL reset_late_write: %0d bad cycles required 0 (LO=%h)", late, LO);
    end
    $display("reset midflight: busy=%b HI=%h LO=%h", busy, HI, LO);
  endtask

  initial begin
    reset = 1'b1; mdu_op = MDU_NONE; A = '0; B = '0;
    test_reset();
    test_mult();
    test_multu_divu();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
